// File: rtl/apb_pkg.sv
// Shared types for the APB memory completer.
// FSM states, response codes and default bus widths.
package apb_pkg;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 32;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  typedef enum logic {
    OKAY,
    SLVERR
  } apb_resp_e;

endpackage

// File: rtl/apb_mem_array.sv
// Single-port storage: DEPTH x DATA_W, sync write, registered read.
// Ports: clk_i, we_i, re_i, addr_i, wdata_i -> rdata_o.
module apb_mem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int AW     = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] memory [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) memory[addr_i] <= wdata_i;
    if (re_i) rdata_q <= memory[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_mem_completer.sv
// APB3 completer in front of a word-addressed memory, with wait states.
// Ports: clk, Rst, PAddr, PSel, PEnable, PWrite, PWData -> PRData, PReady, PSlvErr.
module apb_mem_completer
  import apb_pkg::*;
#(
  parameter int              ADDR_W      = APB_ADDR_W,
  parameter int              DATA_W      = APB_DATA_W,
  parameter int              DEPTH       = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] PAddr,
  input  logic              PSel,
  input  logic              PEnable,
  input  logic              PWrite,
  input  logic [DATA_W-1:0] PWData,
  output logic [DATA_W-1:0] PRData,
  output logic              PReady,
  output logic              PSlvErr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] DEPTH_X = 33'(DEPTH);

  apb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  apb_resp_e         resp_q, resp_d;
  logic              rvld_q, rvld_d;

  logic [ADDR_W-1:0] off;
  logic              oor;
  logic              setup;
  logic              done;
  logic              mem_we;
  logic              mem_re;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  assign off   = PAddr - BASE_ADDR;
  assign oor   = (PAddr < BASE_ADDR) || (33'(off) >= DEPTH_X);
  assign setup = PSel && !PEnable;
  assign done  = (state_q == ACCESS) && PSel && PEnable
              && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    rvld_d  = rvld_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Access strobe without a setup cycle is dropped here.
        if (setup) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
          idx_d   = off[AW-1:0];
          wr_d    = PWrite;
          wdata_d = PWData;
          resp_d  = oor ? SLVERR : OKAY;
          rvld_d  = !PWrite && !oor;
          mem_re  = !PWrite && !oor;
        end
      end
      ACCESS: begin
        if (!PSel) begin
          state_d = IDLE;
        end else if (PEnable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
            mem_we  = wr_q && (resp_q == OKAY);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      resp_q  <= OKAY;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      rvld_q  <= rvld_d;
    end
  end

  // Reads use the live address in setup; writes use the latched index.
  assign mem_addr = (state_q == IDLE) ? off[AW-1:0] : idx_q;

  apb_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) mem (
    .clk_i   (clk),
    .we_i    (mem_we && !Rst),
    .re_i    (mem_re && !Rst),
    .addr_i  (mem_addr),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  assign PRData  = rvld_q ? mem_rdata : '0;
  assign PReady  = done;
  assign PSlvErr = done && (resp_q == SLVERR);

endmodule

// File: tb/tb_apb_mem_completer.sv
// Directed bench for apb_mem_completer (WAIT_STATES 1 and 0 instances).
// Vector table plus hand-written abort and reset sequences.
module tb_apb_mem_completer;

  logic        clk = 1'b0;
  logic        Rst;
  logic [15:0] PAddr;
  logic        PSel;
  logic        PEnable;
  logic        PWrite;
  logic [31:0] PWData;
  logic        use0;

  logic        psel1, psel0;
  logic [31:0] PRData1, PRData0;
  logic        PReady1, PReady0;
  logic        PSlvErr1, PSlvErr0;
  logic [31:0] rdata;
  logic        rdy, err;

  int checks = 0;
  int errors = 0;

  assign psel1 = PSel && !use0;
  assign psel0 = PSel && use0;
  assign rdy   = use0 ? PReady0 : PReady1;
  assign err   = use0 ? PSlvErr0 : PSlvErr1;
  assign rdata = use0 ? PRData0 : PRData1;

  apb_mem_completer #(.WAIT_STATES(1)) dut1 (
    .clk     (clk),
    .Rst     (Rst),
    .PAddr   (PAddr),
    .PSel    (psel1),
    .PEnable (PEnable),
    .PWrite  (PWrite),
    .PWData  (PWData),
    .PRData  (PRData1),
    .PReady  (PReady1),
    .PSlvErr (PSlvErr1)
  );

  apb_mem_completer #(.WAIT_STATES(0)) dut0 (
    .clk     (clk),
    .Rst     (Rst),
    .PAddr   (PAddr),
    .PSel    (psel0),
    .PEnable (PEnable),
    .PWrite  (PWrite),
    .PWData  (PWData),
    .PRData  (PRData0),
    .PReady  (PReady0),
    .PSlvErr (PSlvErr0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // One transfer; returns access-phase cycle count incl. the PReady cycle.
  task automatic xfer(input logic wr, input logic [15:0] a,
                      input logic [31:0] d, output logic [31:0] rd,
                      output logic er, output int cyc);
    bit fin;
    @(posedge clk); #1;
    PSel = 1'b1; PEnable = 1'b0;
    PWrite = wr; PAddr = a; PWData = d;
    @(posedge clk); #1;
    PEnable = 1'b1;
    PAddr = ~a; PWData = ~d;
    cyc = 0; rd = '0; er = 1'b0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (rdy) begin
        rd = rdata; er = err; fin = 1'b1;
      end else begin
        chk("slverr_while_wait", {31'd0, err}, 32'd0);
        if (cyc >= 20) begin
          checks++; errors++;
          $display("FAIL timeout waiting PReady got %0d cycles want <20", cyc);
          fin = 1'b1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    PSel = 1'b0; PEnable = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t v[9];

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cyc;

    v[0] = '{1'b1, 16'h0000, 32'h1111_1111, 32'h0, 1'b0};
    v[1] = '{1'b1, 16'h0050, 32'h0000_0050, 32'h0, 1'b0};
    v[2] = '{1'b0, 16'h0050, 32'h0,         32'h0000_0050, 1'b0};
    v[3] = '{1'b1, 16'h0100, 32'h0000_1234, 32'h0, 1'b1};
    v[4] = '{1'b0, 16'h0100, 32'h0,         32'h0, 1'b1};
    v[5] = '{1'b1, 16'h00FF, 32'hCAFE_F00D, 32'h0, 1'b0};
    v[6] = '{1'b0, 16'h00FF, 32'h0,         32'hCAFE_F00D, 1'b0};
    v[7] = '{1'b0, 16'h0000, 32'h0,         32'h1111_1111, 1'b0};
    v[8] = '{1'b1, 16'hFFFF, 32'h0BAD_BAD0, 32'h0, 1'b1};

    Rst = 1'b1; PSel = 1'b0; PEnable = 1'b0; PWrite = 1'b0;
    PAddr = '0; PWData = '0; use0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 Rst = 1'b0;
    @(negedge clk);
    chk("rst_pready1", {31'd0, PReady1}, 32'd0);
    chk("rst_pslverr1", {31'd0, PSlvErr1}, 32'd0);
    chk("rst_prdata1", PRData1, 32'd0);
    chk("rst_pready0", {31'd0, PReady0}, 32'd0);
    chk("rst_prdata0", PRData0, 32'd0);

    for (int i = 0; i < 9; i++) begin
      xfer(v[i].wr, v[i].a, v[i].d, rd, er, cyc);
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'd2);
      chk($sformatf("vec%0d_slverr", i), {31'd0, er}, {31'd0, v[i].exp_err});
      chk($sformatf("vec%0d_prdata", i), rd, v[i].exp_rd);
    end
    idle();
    chk("mem_50", dut1.mem.memory[8'h50], 32'h0000_0050);
    chk("mem_00_untouched", dut1.mem.memory[8'h00], 32'h1111_1111);
    chk("mem_ff", dut1.mem.memory[8'hFF], 32'hCAFE_F00D);

    use0 = 1'b1;
    xfer(1'b1, 16'h0010, 32'hA5A5_0001, rd, er, cyc);
    chk("ws0_wr_cycles", 32'(cyc), 32'd1);
    chk("ws0_wr_slverr", {31'd0, er}, 32'd0);
    xfer(1'b0, 16'h0010, 32'h0, rd, er, cyc);
    chk("ws0_rd_cycles", 32'(cyc), 32'd1);
    chk("ws0_rd_data", rd, 32'hA5A5_0001);
    idle();
    chk("ws0_mem_10", dut0.mem.memory[8'h10], 32'hA5A5_0001);
    use0 = 1'b0;

    xfer(1'b1, 16'h0020, 32'h0102_0304, rd, er, cyc);
    @(posedge clk); #1;
    PSel = 1'b1; PEnable = 1'b0; PWrite = 1'b1;
    PAddr = 16'h0020; PWData = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      PSel = 1'b0; PEnable = 1'b1;
      @(negedge clk);
      chk($sformatf("abort_pready_%0d", k), {31'd0, PReady1}, 32'd0);
    end
    idle();
    @(posedge clk);
    chk("abort_mem_20", dut1.mem.memory[8'h20], 32'h0102_0304);
    xfer(1'b0, 16'h0020, 32'h0, rd, er, cyc);
    chk("after_abort_cycles", 32'(cyc), 32'd2);
    chk("after_abort_data", rd, 32'h0102_0304);

    xfer(1'b1, 16'h0030, 32'h0A0B_0C0D, rd, er, cyc);
    xfer(1'b0, 16'h0050, 32'h0, rd, er, cyc);
    @(posedge clk); #1;
    PSel = 1'b1; PEnable = 1'b0; PWrite = 1'b1;
    PAddr = 16'h0030; PWData = 32'h7777_7777;
    @(posedge clk); #1;
    PEnable = 1'b1; Rst = 1'b1;
    @(posedge clk); #1;
    Rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_pready", {31'd0, PReady1}, 32'd0);
    chk("rst_mid_pslverr", {31'd0, PSlvErr1}, 32'd0);
    chk("rst_mid_prdata", PRData1, 32'd0);
    idle();
    @(posedge clk);
    chk("rst_mid_mem_30", dut1.mem.memory[8'h30], 32'h0A0B_0C0D);
    xfer(1'b0, 16'h0030, 32'h0, rd, er, cyc);
    chk("after_rst_cycles", 32'(cyc), 32'd2);
    chk("after_rst_data", rd, 32'h0A0B_0C0D);
    chk("after_rst_slverr", {31'd0, er}, 32'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
